// File: rtl/conv_channel_injector.sv
// Channel model between convolutional encoder and Viterbi decoder: one-cycle symbol path with
// programmable error injection and BER counters. Define CHAN_ERR_LOG_EN to add first/last error logging.
module conv_channel_injector #(
    parameter int                SYM_W       = 2,
    parameter int                PERIOD_LOG2 = 4,
    parameter int                BURST_LEN   = 2,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    input  logic [1:0]       mode_i,
    input  logic [SYM_W-1:0] err_mask_i,
    input  logic [7:0]       thresh_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic [SYM_W-1:0] err_o,
    output logic [CNT_W-1:0] word_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o,
    output logic             done_o
`ifdef CHAN_ERR_LOG_EN
    ,
    output logic [CNT_W-1:0] first_err_o,
    output logic [CNT_W-1:0] last_err_o,
    output logic             log_valid_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int                     PHASE_START_I = 2**PERIOD_LOG2 - BURST_LEN;
    localparam logic [PERIOD_LOG2-1:0] PHASE_START   = PHASE_START_I[PERIOD_LOG2-1:0];

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  word_ct_q, bit_err_ct_q;
    logic              hit_p0, in_window_p0, last_word_p0, corrupt_p0;
    logic [SYM_W-1:0]  mask_p0;
    logic              vld_p1;
    logic [SYM_W-1:0]  sym_p1, err_p1;

    function automatic logic [CNT_W-1:0] popcount(input logic [SYM_W-1:0] m);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SYM_W; i++)
            n = n + CNT_W'(m[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // x^16+x^14+x^13+x^11+1, shifting toward bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[LFSR_W-1:1]};
    endfunction

    // Stage p0: decide corruption for the word currently on the inputs
    always_comb begin
        hit_p0 = 1'b0;
        case (mode_i)
            2'b01:   hit_p0 = word_ct_q[PERIOD_LOG2-1:0] >= PHASE_START;
            2'b10:   hit_p0 = lfsr_q[7:0] < thresh_i;
            2'b11:   hit_p0 = 1'b1;
            default: hit_p0 = 1'b0;
        endcase
    end

    assign in_window_p0 = (limit_i == '0) || (word_ct_q < limit_i);
    assign last_word_p0 = (limit_i != '0) && (word_ct_q == limit_i - CNT_W'(1));
    assign corrupt_p0   = (state_q != DONE) && in_window_p0 && hit_p0 && !clear_i;
    assign mask_p0      = corrupt_p0 ? err_mask_i : '0;

    always_comb begin
        state_d = state_q;
        if (clear_i)
            state_d = IDLE;
        else if (valid_i) begin
            case (state_q)
                IDLE:    state_d = last_word_p0 ? DONE : RUN;
                RUN:     state_d = last_word_p0 ? DONE : RUN;
                default: state_d = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_ct_q    <= '0;
            bit_err_ct_q <= '0;
            lfsr_q       <= LFSR_SEED;
        end else if (clear_i) begin
            word_ct_q    <= '0;
            bit_err_ct_q <= '0;
            lfsr_q       <= LFSR_SEED;
        end else if (valid_i) begin
            word_ct_q    <= word_ct_q + CNT_W'(1);
            bit_err_ct_q <= sat_add(bit_err_ct_q, popcount(mask_p0));
            lfsr_q       <= lfsr_next(lfsr_q);
        end
    end

    // Stage p1: registered symbol and applied mask
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            sym_p1 <= '0;
            err_p1 <= '0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                sym_p1 <= sym_i ^ mask_p0;
                err_p1 <= mask_p0;
            end
        end
    end

`ifdef CHAN_ERR_LOG_EN
    logic [CNT_W-1:0] first_err_q, last_err_q;
    logic             log_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_q <= '0;
            last_err_q  <= '0;
            log_valid_q <= 1'b0;
        end else if (clear_i) begin
            first_err_q <= '0;
            last_err_q  <= '0;
            log_valid_q <= 1'b0;
        end else if (valid_i && corrupt_p0) begin
            if (!log_valid_q)
                first_err_q <= word_ct_q;
            last_err_q  <= word_ct_q;
            log_valid_q <= 1'b1;
        end
    end

    assign first_err_o = first_err_q;
    assign last_err_o  = last_err_q;
    assign log_valid_o = log_valid_q;
`endif

    assign valid_o      = vld_p1;
    assign sym_o        = sym_p1;
    assign err_o        = err_p1;
    assign word_ct_o    = word_ct_q;
    assign bit_err_ct_o = bit_err_ct_q;
    assign done_o       = (state_q == DONE);

endmodule
